mem_resp_router: RTL and testbench

- Return-path companion to the memory-address select mux in the multicycle core.
- Every accepted read request records its originator: instruction fetch (PCNext) or data load (calculated address). It also records the low address bits and funct3.
- Each in-order memory response is routed to the instruction output or the load-data output.
- Load data is aligned and sign/zero-extended before it leaves the block.

---
 rtl/mem_resp_pkg.sv | 22 ++
 rtl/req_tag_fifo.sv | 69 ++++++
 rtl/mem_resp_router.sv | 147 ++++++++++++++
 tb/tb_mem_resp_router.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory response router: load funct3 codes,
// address-mux select encoding and the per-request tag recorded at issue time.
package mem_resp_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam logic SEL_FETCH = 1'b0;
    localparam logic SEL_LOAD  = 1'b1;

    typedef struct packed {
        logic       sel;
        logic [2:0] addr_lsb;
        logic [2:0] funct3;
    } req_tag_t;

endpackage

// File: rtl/req_tag_fifo.sv
// Synchronous FIFO of request tags; one entry per outstanding memory read.
// Full/empty derive from the registered count only, so there is no same-cycle bypass.
module req_tag_fifo
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  req_tag_t wdata_i,
    input  logic     pop_i,
    output req_tag_t rdata_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    req_tag_t        mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mem_resp_router.sv
// Routes in-order memory read responses to the instruction or load-data output,
// aligning and extending load data using the tag recorded when the request issued.
module mem_resp_router
    import mem_resp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_req_valid,
    input  logic                  i_req_sel,
    input  logic [2:0]            i_req_addr_lsb,
    input  logic [2:0]            i_req_funct3,
    output logic                  o_req_ready,
    input  logic                  i_resp_valid,
    input  logic [DATA_WIDTH-1:0] i_resp_data,
    output logic                  o_resp_ready,
    output logic [31:0]           o_instr,
    output logic                  o_instr_valid,
    output logic [63:0]           o_load_data,
    output logic                  o_load_valid,
    output logic                  o_err
);

    req_tag_t push_tag, head_tag;
    logic     full, empty, push, pop;

    logic [DATA_WIDTH-1:0] shifted;
    logic [31:0]           fetch_word;
    logic [63:0]           load_ext;
    logic                  load_bad;
    logic                  fetch_bad;

    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [63:0] load_q, load_d;
    logic        load_valid_q, load_valid_d;
    logic        err_q, err_d;

    assign o_req_ready  = ~full;
    assign o_resp_ready = ~empty;
    assign push         = i_req_valid & o_req_ready;
    assign pop          = i_resp_valid & o_resp_ready;

    assign push_tag = '{sel: i_req_sel, addr_lsb: i_req_addr_lsb, funct3: i_req_funct3};

    req_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk_i   (clk),
        .rst_i   (arst),
        .push_i  (push),
        .wdata_i (push_tag),
        .pop_i   (pop),
        .rdata_o (head_tag),
        .full_o  (full),
        .empty_o (empty)
    );

    // The right shift zero-fills, which gives misaligned loads their zeroed upper bytes.
    always_comb begin
        shifted    = i_resp_data >> {head_tag.addr_lsb, 3'b000};
        fetch_word = head_tag.addr_lsb[2] ? i_resp_data[63:32] : i_resp_data[31:0];
        fetch_bad  = (head_tag.addr_lsb[1:0] != 2'b00);
        load_ext   = '0;
        load_bad   = 1'b0;
        case (head_tag.funct3)
            LB:  load_ext = {{56{shifted[7]}}, shifted[7:0]};
            LH: begin
                load_ext = {{48{shifted[15]}}, shifted[15:0]};
                load_bad = head_tag.addr_lsb[0];
            end
            LW: begin
                load_ext = {{32{shifted[31]}}, shifted[31:0]};
                load_bad = (head_tag.addr_lsb[1:0] != 2'b00);
            end
            LD: begin
                load_ext = shifted[63:0];
                load_bad = (head_tag.addr_lsb != 3'b000);
            end
            LBU: load_ext = {56'd0, shifted[7:0]};
            LHU: begin
                load_ext = {48'd0, shifted[15:0]};
                load_bad = head_tag.addr_lsb[0];
            end
            LWU: begin
                load_ext = {32'd0, shifted[31:0]};
                load_bad = (head_tag.addr_lsb[1:0] != 2'b00);
            end
            default: begin
                load_ext = '0;
                load_bad = 1'b1;
            end
        endcase
    end

    always_comb begin
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        load_d        = load_q;
        load_valid_d  = 1'b0;
        err_d         = err_q;
        // A response with nothing outstanding is left unconsumed but flagged.
        if (i_resp_valid && empty) begin
            err_d = 1'b1;
        end
        if (pop) begin
            if (head_tag.sel == SEL_FETCH) begin
                instr_d       = fetch_word;
                instr_valid_d = 1'b1;
                if (fetch_bad) begin
                    err_d = 1'b1;
                end
            end else begin
                load_d       = load_ext;
                load_valid_d = 1'b1;
                if (load_bad) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            load_q        <= '0;
            load_valid_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            load_q        <= load_d;
            load_valid_q  <= load_valid_d;
            err_q         <= err_d;
        end
    end

    assign o_instr       = instr_q;
    assign o_instr_valid = instr_valid_q;
    assign o_load_data   = load_q;
    assign o_load_valid  = load_valid_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_mem_resp_router.sv
// Directed self-checking bench for mem_resp_router: routing, extension, FIFO
// full/empty handshakes, sticky error and reset behaviour.
module tb_mem_resp_router;
    import mem_resp_pkg::*;

    logic        clk = 1'b0;
    logic        arst;
    logic        i_req_valid;
    logic        i_req_sel;
    logic [2:0]  i_req_addr_lsb;
    logic [2:0]  i_req_funct3;
    logic        o_req_ready;
    logic        i_resp_valid;
    logic [63:0] i_resp_data;
    logic        o_resp_ready;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic [63:0] o_load_data;
    logic        o_load_valid;
    logic        o_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_resp_router #(
        .DATA_WIDTH (64),
        .DEPTH      (4)
    ) dut (
        .clk            (clk),
        .arst           (arst),
        .i_req_valid    (i_req_valid),
        .i_req_sel      (i_req_sel),
        .i_req_addr_lsb (i_req_addr_lsb),
        .i_req_funct3   (i_req_funct3),
        .o_req_ready    (o_req_ready),
        .i_resp_valid   (i_resp_valid),
        .i_resp_data    (i_resp_data),
        .o_resp_ready   (o_resp_ready),
        .o_instr        (o_instr),
        .o_instr_valid  (o_instr_valid),
        .o_load_data    (o_load_data),
        .o_load_valid   (o_load_valid),
        .o_err          (o_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic sel, input logic [2:0] lsb, input logic [2:0] f3);
        i_req_valid    = 1'b1;
        i_req_sel      = sel;
        i_req_addr_lsb = lsb;
        i_req_funct3   = f3;
        tick();
        i_req_valid    = 1'b0;
    endtask

    task automatic do_resp(input logic [63:0] d);
        i_resp_valid = 1'b1;
        i_resp_data  = d;
        tick();
        i_resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        tick();
        arst = 1'b0;
    endtask

    initial begin
        arst           = 1'b1;
        i_req_valid    = 1'b0;
        i_req_sel      = 1'b0;
        i_req_addr_lsb = 3'b000;
        i_req_funct3   = 3'b000;
        i_resp_valid   = 1'b0;
        i_resp_data    = '0;
        tick();
        tick();
        arst = 1'b0;

        chk("rst_instr", o_instr, 0);
        chk("rst_load", o_load_data, 0);
        chk("rst_ivalid", o_instr_valid, 0);
        chk("rst_lvalid", o_load_valid, 0);
        chk("rst_err", o_err, 0);
        chk("rst_req_ready", o_req_ready, 1);
        chk("rst_resp_ready", o_resp_ready, 0);

        // Fetch from upper word
        do_req(SEL_FETCH, 3'b100, 3'b000);
        chk("f1_resp_ready", o_resp_ready, 1);
        do_resp(64'h11223344_55667788);
        chk("f1_instr", o_instr, 64'h11223344);
        chk("f1_ivalid", o_instr_valid, 1);
        chk("f1_lvalid", o_load_valid, 0);
        chk("f1_err", o_err, 0);
        tick();
        chk("f1_ivalid_drop", o_instr_valid, 0);
        chk("f1_instr_hold", o_instr, 64'h11223344);

        // lb then lbu at byte 1
        do_req(SEL_LOAD, 3'b001, LB);
        do_resp(64'h00000000_000080FF);
        chk("lb_data", o_load_data, 64'hFFFFFFFF_FFFFFF80);
        chk("lb_lvalid", o_load_valid, 1);
        chk("lb_ivalid", o_instr_valid, 0);
        do_req(SEL_LOAD, 3'b001, LBU);
        do_resp(64'h00000000_000080FF);
        chk("lbu_data", o_load_data, 64'h00000000_00000080);
        chk("lbu_err", o_err, 0);
        tick();
        chk("lbu_lvalid_drop", o_load_valid, 0);
        chk("lbu_hold", o_load_data, 64'h00000000_00000080);

        // Four outstanding, fifth held, in-order routing
        do_req(SEL_FETCH, 3'b000, 3'b000);
        do_req(SEL_LOAD, 3'b100, LW);
        do_req(SEL_FETCH, 3'b100, 3'b000);
        chk("fill3_req_ready", o_req_ready, 1);
        do_req(SEL_LOAD, 3'b000, LD);
        chk("full_req_ready", o_req_ready, 0);
        do_req(SEL_FETCH, 3'b000, 3'b000);
        chk("held_req_ready", o_req_ready, 0);
        do_resp(64'hAAAABBBB_CCCCDDDD);
        chk("q1_instr", o_instr, 64'hCCCCDDDD);
        chk("q1_ivalid", o_instr_valid, 1);
        do_resp(64'h80000001_12345678);
        chk("q2_load", o_load_data, 64'hFFFFFFFF_80000001);
        chk("q2_lvalid", o_load_valid, 1);
        chk("q2_ivalid", o_instr_valid, 0);
        do_resp(64'hDEADBEEF_00000013);
        chk("q3_instr", o_instr, 64'hDEADBEEF);
        do_resp(64'h01234567_89ABCDEF);
        chk("q4_load", o_load_data, 64'h01234567_89ABCDEF);
        chk("q4_err", o_err, 0);
        chk("q4_empty", o_resp_ready, 0);

        // Full FIFO with simultaneous request and response
        do_req(SEL_FETCH, 3'b000, 3'b000);
        do_req(SEL_FETCH, 3'b000, 3'b000);
        do_req(SEL_FETCH, 3'b000, 3'b000);
        do_req(SEL_FETCH, 3'b000, 3'b000);
        chk("sim_full", o_req_ready, 0);
        i_req_valid    = 1'b1;
        i_req_sel      = SEL_FETCH;
        i_req_addr_lsb = 3'b100;
        i_resp_valid   = 1'b1;
        i_resp_data    = 64'h55555555_66666666;
        tick();
        i_resp_valid   = 1'b0;
        chk("sim_instr", o_instr, 64'h66666666);
        chk("sim_ivalid", o_instr_valid, 1);
        chk("sim_slot_freed", o_req_ready, 1);
        tick();
        i_req_valid = 1'b0;
        chk("sim_refull", o_req_ready, 0);
        do_resp(64'h00000001_00000002);
        do_resp(64'h00000003_00000004);
        do_resp(64'h00000005_00000006);
        chk("sim_drain3", o_instr, 64'h00000006);
        do_resp(64'h00000007_00000008);
        chk("sim_drain4_upper", o_instr, 64'h00000007);
        chk("sim_drained", o_resp_ready, 0);
        chk("sim_err", o_err, 0);

        // Push and pop together below full keeps count
        do_req(SEL_FETCH, 3'b000, 3'b000);
        i_req_valid    = 1'b1;
        i_req_sel      = SEL_FETCH;
        i_req_addr_lsb = 3'b100;
        i_resp_valid   = 1'b1;
        i_resp_data    = 64'h9999AAAA_BBBBCCCC;
        tick();
        i_req_valid  = 1'b0;
        i_resp_valid = 1'b0;
        chk("pp_instr", o_instr, 64'hBBBBCCCC);
        chk("pp_count1", o_resp_ready, 1);
        do_resp(64'h9999AAAA_BBBBCCCC);
        chk("pp_instr2", o_instr, 64'h9999AAAA);
        chk("pp_empty", o_resp_ready, 0);

        // Response with empty FIFO
        chk("emp_resp_ready", o_resp_ready, 0);
        do_resp(64'h12345678_9ABCDEF0);
        chk("emp_err", o_err, 1);
        chk("emp_ivalid", o_instr_valid, 0);
        chk("emp_lvalid", o_load_valid, 0);
        tick();
        tick();
        chk("emp_err_sticky", o_err, 1);
        do_reset();
        chk("rst2_err", o_err, 0);
        chk("rst2_instr", o_instr, 0);
        chk("rst2_load", o_load_data, 0);
        chk("rst2_ivalid", o_instr_valid, 0);
        chk("rst2_lvalid", o_load_valid, 0);

        // Reset mid-operation discards outstanding tags
        do_req(SEL_LOAD, 3'b000, LD);
        do_req(SEL_FETCH, 3'b000, 3'b000);
        do_reset();
        chk("midrst_resp_ready", o_resp_ready, 0);
        chk("midrst_req_ready", o_req_ready, 1);
        do_resp(64'h0);
        chk("midrst_err", o_err, 1);
        do_reset();

        // Misaligned lw still delivered
        do_req(SEL_LOAD, 3'b010, LW);
        do_resp(64'h11223344_55667788);
        chk("lw_mis_data", o_load_data, 64'h00000000_33445566);
        chk("lw_mis_err", o_err, 1);
        do_reset();

        // Misaligned lh at top byte: upper byte zero-filled before sign extension
        do_req(SEL_LOAD, 3'b111, LH);
        do_resp(64'hFF000000_00000000);
        chk("lh_mis_data", o_load_data, 64'h00000000_000000FF);
        chk("lh_mis_err", o_err, 1);
        do_reset();

        // Misaligned fetch still delivered
        do_req(SEL_FETCH, 3'b010, 3'b000);
        do_resp(64'hCAFEF00D_0BADBEEF);
        chk("f_mis_instr", o_instr, 64'h0BADBEEF);
        chk("f_mis_err", o_err, 1);
        do_reset();

        // Aligned lhu sign bit set, then illegal funct3
        do_req(SEL_LOAD, 3'b110, LHU);
        do_resp(64'h8001FFFF_FFFFFFFF);
        chk("lhu_data", o_load_data, 64'h00000000_00008001);
        chk("lhu_err", o_err, 0);
        do_req(SEL_LOAD, 3'b000, 3'b111);
        do_resp(64'hFFFFFFFF_FFFFFFFF);
        chk("f3bad_data", o_load_data, 0);
        chk("f3bad_lvalid", o_load_valid, 1);
        chk("f3bad_err", o_err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
